// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_adr_t            : register address type for the default configuration
//   bypass_sel()         : true when a read port should take same-cycle
//                          writeback data instead of the array contents
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_adr_t;

    // Addresses are passed zero-extended to 32 bits so the same helper serves
    // every NREGS configuration.
    function automatic logic bypass_sel(
        input logic        en,
        input logic        we,
        input logic [31:0] write_adr,
        input logic [31:0] read_adr
    );
        return en && we && (write_adr == read_adr);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard used by decode to spot RAW hazards.
//   clk, rst_n            : clock, asynchronous active-low reset
//   reg_write, write_adr  : writeback, clears the destination's busy bit
//   issue_valid, issue_adr: issuing instruction, sets its destination busy
//   flush                 : clears every busy bit
//   read_adr              : NRD packed source addresses
//   busy_vec              : registered busy bit per register
//   read_busy             : per-port hazard flag for the addressed source
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [AW-1:0]     write_adr,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_adr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] read_adr,
    output logic [NREGS-1:0]  busy_vec,
    output logic [NRD-1:0]    read_busy
);

    logic [NREGS-1:0] busy_next;

    // Priority: flush, then issue (a new producer supersedes the one being
    // written back), then writeback clear.
    always_comb begin
        busy_next = busy_vec;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                busy_next[r] = 1'b0;
            end else if (issue_valid && (issue_adr == AW'(r)) &&
                         !((ZERO_REG != 0) && (r == 0))) begin
                busy_next[r] = 1'b1;
            end else if (reg_write && (write_adr == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port_busy
        logic [AW-1:0] adr;
        assign adr = read_adr[k*AW +: AW];
        // A source being forwarded this cycle is no longer a hazard.
        assign read_busy[k] = busy_vec[adr]
                            && !((ZERO_REG != 0) && (adr == '0))
                            && !bypass_sel(BYPASS != 0, reg_write,
                                           32'(write_adr), 32'(adr));
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_RegWrite, i_write_adr,
//   i_write_data            : writeback port
//   i_read_adr / o_read_data: NRD combinational read ports (packed)
//   o_read_busy             : per-port hazard flag
//   i_issue_valid, i_issue_adr : marks a destination busy at issue
//   i_flush                 : clears all busy bits
//   o_busy_vec              : registered busy bit per register
module register_file_sb
    import rf_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_RegWrite,
    input  logic [AW-1:0]       i_write_adr,
    input  logic [XLEN-1:0]     i_write_data,
    input  logic [NRD*AW-1:0]   i_read_adr,
    output logic [NRD*XLEN-1:0] o_read_data,
    output logic [NRD-1:0]      o_read_busy,
    input  logic                i_issue_valid,
    input  logic [AW-1:0]       i_issue_adr,
    input  logic                i_flush,
    output logic [NREGS-1:0]    o_busy_vec
);

    logic [XLEN-1:0] regs [NREGS];
    logic            write_en;

    assign write_en = i_RegWrite && !((ZERO_REG != 0) && (i_write_adr == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (write_en) begin
            regs[i_write_adr] <= i_write_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0] adr;
        assign adr = i_read_adr[k*AW +: AW];
        always_comb begin
            if ((ZERO_REG != 0) && (adr == '0)) begin
                o_read_data[k*XLEN +: XLEN] = '0;
            end else if (bypass_sel(BYPASS != 0, i_RegWrite,
                                    32'(i_write_adr), 32'(adr))) begin
                o_read_data[k*XLEN +: XLEN] = i_write_data;
            end else begin
                o_read_data[k*XLEN +: XLEN] = regs[adr];
            end
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .reg_write   (i_RegWrite),
        .write_adr   (i_write_adr),
        .issue_valid (i_issue_valid),
        .issue_adr   (i_issue_adr),
        .flush       (i_flush),
        .read_adr    (i_read_adr),
        .busy_vec    (o_busy_vec),
        .read_busy   (o_read_busy)
    );

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: 32x32, 2 ports, zero reg, bypass ----------------
    logic        a_we, a_iv, a_flush;
    logic [4:0]  a_wadr, a_ia;
    logic [31:0] a_wdata;
    logic [9:0]  a_radr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic [31:0] a_vec;

    register_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_RegWrite(a_we), .i_write_adr(a_wadr), .i_write_data(a_wdata),
        .i_read_adr(a_radr), .o_read_data(a_rdata), .o_read_busy(a_rbusy),
        .i_issue_valid(a_iv), .i_issue_adr(a_ia), .i_flush(a_flush),
        .o_busy_vec(a_vec)
    );

    // ---------------- DUT B: 16x64, 3 ports, zero reg, no bypass ----------------
    logic         b_we, b_iv, b_flush;
    logic [3:0]   b_wadr, b_ia;
    logic [63:0]  b_wdata;
    logic [11:0]  b_radr;
    logic [191:0] b_rdata;
    logic [2:0]   b_rbusy;
    logic [15:0]  b_vec;

    register_file_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_RegWrite(b_we), .i_write_adr(b_wadr), .i_write_data(b_wdata),
        .i_read_adr(b_radr), .o_read_data(b_rdata), .o_read_busy(b_rbusy),
        .i_issue_valid(b_iv), .i_issue_adr(b_ia), .i_flush(b_flush),
        .o_busy_vec(b_vec)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of DUT A ----------------
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge, stated register by register.
    task automatic model_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ia, input logic fl);
        for (int r = 0; r < 32; r++) begin
            if (fl) m_busy[r] = 1'b0;
            else if (iv && ia == r && r != 0) m_busy[r] = 1'b1;
            else if (we && wa == r) m_busy[r] = 1'b0;
        end
        if (we && wa != 0) m_regs[wa] = wd;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 0) return 32'h0;
        if (we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    function automatic logic model_rbusy(input logic [4:0] ra, input logic we, input logic [4:0] wa);
        if (ra == 0) return 1'b0;
        if (we && wa == ra) return 1'b0;
        return m_busy[ra];
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic iv, input logic [4:0] ia, input logic fl,
                           input logic [4:0] r0, input logic [4:0] r1);
        a_we = we; a_wadr = wa; a_wdata = wd;
        a_iv = iv; a_ia = ia; a_flush = fl;
        a_radr = {r1, r0};
    endtask

    task automatic idle_b();
        b_we = 0; b_wadr = 0; b_wdata = 0; b_iv = 0; b_ia = 0; b_flush = 0; b_radr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] vec;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    initial begin
        logic        r_we, r_iv, r_fl;
        logic [4:0]  r_wa, r_ia, r_r0, r_r1;
        logic [31:0] r_wd, e0, e1;

        // Fields: we wa wd iv ia fl r0 r1 | d0 d1 b0 b1 vec (vec = busy before this row's edge)
        tbl[0]  = '{0, 0, 0,            0, 0, 0, 0, 1,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,            0, 0, 0, 2, 3,   0, 0, 0, 0, 0};
        tbl[2]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
        tbl[3]  = '{0, 0, 0,            0, 0, 0, 5, 5,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
        tbl[4]  = '{1, 0, 32'h1234,     0, 0, 0, 0, 5,   0, 32'hDEADBEEF, 0, 0, 0};
        tbl[5]  = '{0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0,            1, 7, 0, 7, 7,   0, 0, 0, 0, 0};
        tbl[7]  = '{1, 7, 32'hA5A5A5A5, 0, 0, 0, 5, 7,   32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'h80};
        tbl[8]  = '{0, 0, 0,            1, 9, 0, 7, 9,   32'hA5A5A5A5, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0,            0, 0, 0, 9, 9,   0, 0, 1, 1, 32'h200};
        tbl[10] = '{1, 9, 32'h99,       1, 9, 0, 9, 2,   32'h99, 0, 0, 0, 32'h200};
        tbl[11] = '{0, 0, 0,            0, 0, 0, 9, 9,   32'h99, 32'h99, 1, 1, 32'h200};
        tbl[12] = '{1, 9, 32'h77,       0, 0, 0, 9, 5,   32'h77, 32'hDEADBEEF, 0, 0, 32'h200};
        tbl[13] = '{0, 0, 0,            1, 0, 0, 9, 0,   32'h77, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0,            1, 3, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0,            1, 4, 0, 3, 4,   0, 0, 1, 0, 32'h8};
        tbl[16] = '{0, 0, 0,            1, 31, 0, 3, 4,  0, 0, 1, 1, 32'h18};
        tbl[17] = '{0, 0, 0,            1, 6, 1, 31, 6,  0, 0, 1, 0, 32'h80000018};
        tbl[18] = '{0, 0, 0,            0, 0, 0, 6, 31,  0, 0, 0, 0, 0};

        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        idle_b();
        do_reset();

        // Table phase
        for (int i = 0; i < NVEC; i++) begin
            drive_a(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iv, tbl[i].ia, tbl[i].fl,
                    tbl[i].r0, tbl[i].r1);
            #1;
            check($sformatf("tbl%0d_data0", i), 64'(a_rdata[31:0]),  64'(tbl[i].d0));
            check($sformatf("tbl%0d_data1", i), 64'(a_rdata[63:32]), 64'(tbl[i].d1));
            check($sformatf("tbl%0d_busy0", i), 64'(a_rbusy[0]),     64'(tbl[i].b0));
            check($sformatf("tbl%0d_busy1", i), 64'(a_rbusy[1]),     64'(tbl[i].b1));
            check($sformatf("tbl%0d_vec", i),   64'(a_vec),          64'(tbl[i].vec));
            @(negedge clk);
        end

        // Random phase against the model
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r_we = 1'($urandom_range(0, 1));
            r_wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_wd = $urandom;
            r_iv = 1'($urandom_range(0, 1));
            r_ia = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_fl = ($urandom_range(0, 15) == 0);
            r_r0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_r1 = ($urandom_range(0, 3) == 0) ? r_r0 : 5'($urandom_range(0, 7));
            drive_a(r_we, r_wa, r_wd, r_iv, r_ia, r_fl, r_r0, r_r1);
            exp_q.push_back(model_read(r_r0, r_we, r_wa, r_wd));
            exp_q.push_back(model_read(r_r1, r_we, r_wa, r_wd));
            #1;
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            check("rnd_data0", 64'(a_rdata[31:0]),  64'(e0));
            check("rnd_data1", 64'(a_rdata[63:32]), 64'(e1));
            check("rnd_busy0", 64'(a_rbusy[0]), 64'(model_rbusy(r_r0, r_we, r_wa)));
            check("rnd_busy1", 64'(a_rbusy[1]), 64'(model_rbusy(r_r1, r_we, r_wa)));
            check("rnd_vec",   64'(a_vec),      64'(model_vec()));
            @(posedge clk);
            model_step(r_we, r_wa, r_wd, r_iv, r_ia, r_fl);
            @(negedge clk);
        end
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);

        // DUT B: no bypass, write/read collision returns old value and stays busy
        b_we = 1; b_wadr = 4'd2; b_wdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        b_we = 0; b_iv = 1; b_ia = 4'd2; b_radr = {4'd0, 4'd2, 4'd2};
        #1;
        check("b_after_write", b_rdata[63:0], 64'h0123_4567_89AB_CDEF);
        check("b_busy_pre_issue", 64'(b_rbusy), 64'h0);
        @(negedge clk);
        b_iv = 0; b_we = 1; b_wadr = 4'd2; b_wdata = 64'hFEDC_BA98_7654_3210;
        #1;
        check("b_coll_data0", b_rdata[63:0],    64'h0123_4567_89AB_CDEF);
        check("b_coll_data1", b_rdata[127:64],  64'h0123_4567_89AB_CDEF);
        check("b_coll_data2", b_rdata[191:128], 64'h0);
        check("b_coll_busy",  64'(b_rbusy),     64'h3);
        check("b_coll_vec",   64'(b_vec),       64'h4);
        @(negedge clk);
        b_we = 0;
        #1;
        check("b_post_data0", b_rdata[63:0], 64'hFEDC_BA98_7654_3210);
        check("b_post_busy",  64'(b_rbusy),  64'h0);
        check("b_post_vec",   64'(b_vec),    64'h0);
        b_iv = 1; b_ia = 4'd8;
        @(negedge clk);
        b_iv = 0;

        // Async reset mid-cycle with x8 = 1 and busy[8] = 1 on DUT A
        drive_a(1, 8, 32'h1, 1, 8, 0, 8, 8);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 8, 8);
        #1;
        check("rst_pre_data", 64'(a_rdata[31:0]), 64'h1);
        check("rst_pre_busy", 64'(a_rbusy),       64'h3);
        check("rst_pre_vec8", 64'(a_vec[8]),      64'h1);
        check("b_rst_pre_vec", 64'(b_vec),        64'h100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_vec",     64'(a_vec),          64'h0);
        check("rst_data",    64'(a_rdata[31:0]),  64'h0);
        check("rst_busy",    64'(a_rbusy),        64'h0);
        check("b_rst_vec",   64'(b_vec),          64'h0);
        check("b_rst_data",  b_rdata[63:0],       64'h0);
        // A write held across an edge while in reset must not land.
        drive_a(1, 8, 32'h55, 1, 8, 0, 9, 9);
        @(posedge clk);
        #2;
        drive_a(0, 0, 0, 0, 0, 0, 8, 8);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_no_write", 64'(a_rdata[31:0]), 64'h0);
        check("rst_no_busy",  64'(a_vec),         64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor of the single-issue register file: N read ports, configurable width and depth, hardwired-zero option, and write-to-read bypass.
- Adds a per-register busy scoreboard. The decode stage uses it to detect RAW hazards against in-flight producers.
- Sits between decode/issue (reads, issue marking) and writeback (writes, busy clear) in the RISC-V core.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >= 2)
NRD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and issue marking
BYPASS, 1, 1 = same-cycle writeback data forwarded to matching read ports
(localparam AW = $clog2(NREGS))

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_RegWrite  in  1  writeback write enable
i_write_adr  in  AW  writeback destination
i_write_data  in  XLEN  writeback data
i_read_adr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
o_read_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
o_read_busy  out  NRD  port k source has an outstanding producer (hazard)
i_issue_valid  in  1  an instruction with a destination issues this cycle
i_issue_adr  in  AW  destination of the issuing instruction
i_flush  in  1  synchronous clear of all busy bits (pipeline flush)
o_busy_vec  out  NREGS  registered busy bit per register

Behaviour:
- Reset (i_rst_n low, async): all registers = 0, all busy bits = 0. Hence o_read_data = 0, o_read_busy = 0, o_busy_vec = 0 while in reset and after release until the first write/issue.
- Write: at posedge, if i_RegWrite and not (ZERO_REG and i_write_adr == 0), registers[i_write_adr] <= i_write_data. Visible through the array on the next cycle.
- Read, port k, combinational, in priority order:
  - ZERO_REG and adr == 0 -> 0;
  - else BYPASS and i_RegWrite and i_write_adr == adr -> i_write_data;
  - else registers[adr].
- Latency: 0 cycles for reads; 1 cycle for array update; 0 cycles for forwarded data when BYPASS = 1.
- Busy scoreboard, next-state per register r, evaluated in priority order:
  - i_flush -> 0;
  - else i_issue_valid and i_issue_adr == r and not (ZERO_REG and r == 0) -> 1;
  - else i_RegWrite and i_write_adr == r -> 0;
  - else hold.
- Simultaneous issue and writeback to the same register: set wins, because the new producer supersedes the old one.
- Flush together with issue: flush wins; the issuing instruction is squashed by the flush.
- Writeback to a non-busy register is legal and leaves busy at 0.
- o_read_busy[k]:
  - busy[adr_k];
  - forced 0 if ZERO_REG and adr_k == 0;
  - forced 0 if BYPASS and i_RegWrite and i_write_adr == adr_k (data forwarded this cycle).
  - With BYPASS = 0, a busy source stays busy during its writeback cycle.
- Multiple read ports with the same address return identical data and busy.
- Reset asserted mid-operation: state is cleared immediately; no pending write completes.
- With ZERO_REG = 0, register 0 is an ordinary register.
- Out-of-range addresses cannot occur because NREGS is a power of 2.

Decomposition:
- Shared package rf_pkg: default XLEN/NREGS constants, the address typedef, and a helper function computing bypass-select.
- One natural sub-module: rf_scoreboard (busy vector, flush/issue/writeback priority, per-port busy lookup). The data array, write logic and read muxing stay in the top.

Test Plan:
1. Reset then read all ports at addresses 0..3 -> o_read_data all 0, o_busy_vec = 0.
2. Write x5 = 32'hDEAD_BEEF, next cycle read port0 = 5, port1 = 5 -> both 32'hDEAD_BEEF. Write x0 = 32'h1234 -> x0 reads 0 (ZERO_REG = 1).
3. BYPASS = 1: same cycle i_RegWrite, adr 7, data 32'hA5A5_A5A5, read port1 = 7 -> o_read_data port1 = 32'hA5A5_A5A5 that cycle and o_read_busy[1] = 0 even if x7 is busy.
4. Issue rd = 9 -> next cycle o_busy_vec[9] = 1 and read of 9 gives o_read_busy = 1. Writeback 9 and issue 9 in the same cycle -> busy[9] stays 1. Writeback 9 alone -> busy[9] = 0 next cycle. Issue rd = 0 -> busy[0] stays 0.
5. Set busy on x3, x4, x31, then i_flush with i_issue_valid rd = 6 -> o_busy_vec = 0 next cycle.
6. Assert i_rst_n low asynchronously mid-cycle with x8 = 32'h1 and busy[8] = 1 -> immediately o_busy_vec = 0 and a read of 8 = 0. Repeat with NRD = 3, XLEN = 64, NREGS = 16, BYPASS = 0 -> same-cycle write/read of x2 returns the old value and o_read_busy stays 1.
